// File: rtl/regfile_wb_sink_pkg.sv
// Shared pipeline package: register-file sizing, the clear/ready state type
// and the write-back source selects used elsewhere in the pipeline.
package regfile_wb_sink_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

    localparam logic [1:0] Wb_SelAlu = 2'd0;
    localparam logic [1:0] Wb_SelMem = 2'd1;
    localparam logic [1:0] Wb_SelPc4 = 2'd2;
    localparam logic [1:0] Wb_SelCsr = 2'd3;

endpackage

// File: rtl/regfile_wb_sink_if.sv
// Write-back / decode bus seen by the integer register file.
// The master side drives the write-back and read-address signals;
// the slave side (the register file) returns read data and readiness.
interface regfile_wb_sink_if #(
    parameter int XLEN = regfile_wb_sink_pkg::XLEN,
    parameter int AW   = $clog2(regfile_wb_sink_pkg::NREGS)
);

    logic [XLEN-1:0] WB_RegWData;
    logic [AW-1:0]   WB_RegRd;
    logic            WB_RegWrite;
    logic [AW-1:0]   ID_Rs1;
    logic [AW-1:0]   ID_Rs2;
    logic            ID_Stall;
    logic [XLEN-1:0] RF_Rs1Data;
    logic [XLEN-1:0] RF_Rs2Data;
    logic            RF_Ready;

    modport master (
        output WB_RegWData, WB_RegRd, WB_RegWrite,
        output ID_Rs1, ID_Rs2, ID_Stall,
        input  RF_Rs1Data, RF_Rs2Data, RF_Ready
    );

    modport slave (
        input  WB_RegWData, WB_RegRd, WB_RegWrite,
        input  ID_Rs1, ID_Rs2, ID_Stall,
        output RF_Rs1Data, RF_Rs2Data, RF_Ready
    );

endinterface

// File: rtl/regfile_wb_sink_rf_read_port.sv
// One registered read port of the register file: latches the read address,
// masks x0, forwards a same-cycle write-back, and holds its output while
// decode is stalled (still picking up a write to the held register).
module rf_read_port
    import regfile_wb_sink_pkg::*;
#(
    parameter int XLEN = regfile_wb_sink_pkg::XLEN,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            stall,
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            wb_write,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rdata
);

    logic [AW-1:0] rs_q;
    logic          rs_is_zero;
    logic          held_is_zero;
    logic          hit_new;
    logic          hit_held;

    assign rs_is_zero   = (rs == AW'(REG_ZERO));
    assign held_is_zero = (rs_q == AW'(REG_ZERO));
    assign hit_new      = wb_write && (wb_rd == rs);
    assign hit_held     = wb_write && (wb_rd == rs_q) && !held_is_zero;

    // Sample a new address when decode advances, otherwise hold but refresh on a write to the held register
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q  <= '0;
            rdata <= '0;
        end else if (en) begin
            if (!stall) begin
                rs_q <= rs;
                if (rs_is_zero) begin
                    rdata <= '0;
                end else if (hit_new) begin
                    rdata <= wb_data;
                end else begin
                    rdata <= mem_rdata;
                end
            end else if (hit_held) begin
                rdata <= wb_data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Integer register file at the end of the write-back stage.
// Holds the storage array (no reset on the array itself), a clear sequencer
// that zeroes every entry after reset, the write path, and two read ports.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int XLEN  = regfile_wb_sink_pkg::XLEN,
    parameter int NREGS = regfile_wb_sink_pkg::NREGS
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sink_if.slave   bus
);

    localparam int            AW       = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    rf_state_t       state;
    logic [AW-1:0]   clr_cnt;
    logic            ready_q;
    logic            wb_commit;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] rs1_mem;
    logic [XLEN-1:0] rs2_mem;

    assign wb_commit = (state == RF_READY) && bus.WB_RegWrite &&
                       (bus.WB_RegRd != AW'(REG_ZERO));

    // Clear sequencer: walk every entry once after reset, then report ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_cnt == LAST_REG) begin
                        state   <= RF_READY;
                        clr_cnt <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= RF_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage writes: zeroes while clearing, write-back data once ready; nothing on a reset edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wb_commit) begin
                mem[bus.WB_RegRd] <= bus.WB_RegWData;
            end
        end
    end

    assign rs1_mem      = mem[bus.ID_Rs1];
    assign rs2_mem      = mem[bus.ID_Rs2];
    assign bus.RF_Ready = ready_q;

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_port1 (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RF_READY),
        .stall     (bus.ID_Stall),
        .rs        (bus.ID_Rs1),
        .mem_rdata (rs1_mem),
        .wb_write  (bus.WB_RegWrite),
        .wb_rd     (bus.WB_RegRd),
        .wb_data   (bus.WB_RegWData),
        .rdata     (bus.RF_Rs1Data)
    );

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_port2 (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RF_READY),
        .stall     (bus.ID_Stall),
        .rs        (bus.ID_Rs2),
        .mem_rdata (rs2_mem),
        .wb_write  (bus.WB_RegWrite),
        .wb_rd     (bus.WB_RegRd),
        .wb_data   (bus.WB_RegWData),
        .rdata     (bus.RF_Rs2Data)
    );

endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Integer register file at the consuming end of the write-back interface.
- Accepts WB_RegWData / WB_RegRd / WB_RegWrite from the write-back stage and serves two registered read ports to decode.
- After reset, a clear FSM zeroes every entry. This lets the array map to memory without a reset on the storage.
- Same-cycle write-to-read bypass, and a hold mechanism so ID stalls never return stale data.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- AW, $clog2(NREGS), register address width; derived, do not override.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- WB_RegWData  in  XLEN  write data from write-back.
- WB_RegRd  in  AW  destination register from write-back.
- WB_RegWrite  in  1  write enable from write-back.
- ID_Rs1  in  AW  read address, port 1.
- ID_Rs2  in  AW  read address, port 2.
- ID_Stall  in  1  hold the read ports; addresses are not sampled.
- RF_Rs1Data  out  XLEN  registered read data, port 1.
- RF_Rs2Data  out  XLEN  registered read data, port 2.
- RF_Ready  out  1  high once the clear sequence is complete.

Behaviour:
- Reset is synchronous and active-high on the clk posedge; it is the already-decided scheme for this block.
- Reset values:
  - state = RF_CLEAR, clr_cnt = 0.
  - RF_Ready = 0.
  - RF_Rs1Data = RF_Rs2Data = 0.
  - Latched read addresses = 0.
  - Array contents are not reset directly.
- RF_CLEAR:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt++.
  - When clr_cnt == NREGS-1, go to RF_READY on the next edge; RF_Ready = 1 from that edge.
  - Total clear time is NREGS cycles after rst deasserts.
  - All WB writes are ignored during this state.
  - Read outputs stay 0; ID_Stall is ignored.
- RF_READY, write:
  - On posedge, if WB_RegWrite && WB_RegRd != 0, then mem[WB_RegRd] <= WB_RegWData.
  - A write to x0 is discarded.
- RF_READY, read (each port independent), when ID_Stall = 0:
  - Latch rsN.
  - Output rule, in priority order:
    - RF_RsNData <= 0 if rsN == 0.
    - Else WB_RegWData if WB_RegWrite && WB_RegRd == rsN (bypass).
    - Else mem[rsN].
  - Read latency is 1 cycle from address to data.
- RF_READY, read, when ID_Stall = 1:
  - Latched address and output are held.
  - Exception: if WB_RegWrite && WB_RegRd == latched address && latched address != 0, the output updates to WB_RegWData on that edge.
- Both ports may read the same address; both follow identical rules.
- A simultaneous WB write and reads on both ports resolve in a single cycle; there is no structural stall.
- rst asserted mid-operation, including mid-clear:
  - Returns to RF_CLEAR with clr_cnt = 0 and drops RF_Ready the next edge.
  - Any in-flight write on that edge is discarded.
- clr_cnt is AW bits wide. NREGS equal to a power of two must not wrap before the state transition.

Decomposition:
- Shared pipeline package:
  - Add XLEN, NREGS, REG_ZERO (5'd0).
  - Add typedef enum logic {RF_CLEAR, RF_READY} rf_state_t.
  - The existing Wb_* select constants stay there.
- Sub-module rf_read_port, instantiated twice:
  - Contains the address latch, bypass compare, stall-hold and x0 masking.
  - Takes the array read data and WB write signals as inputs.
- Top level holds the storage, the clear FSM and the write logic.

Test Plan:
- Clear sequence: pulse rst for 1 cycle, idle. RF_Ready must be 0 for exactly 32 cycles, then 1. Reading x1..x31 afterward must return 0.
- Write then read: write x5 = 0xDEADBEEF. The next cycle set ID_Rs1 = 5. One cycle later RF_Rs1Data must be 0xDEADBEEF.
- Bypass: in the same cycle, WB_RegWrite = 1, WB_RegRd = 7, WB_RegWData = 0x12345678, with ID_Rs1 = ID_Rs2 = 7. The next cycle both outputs must be 0x12345678.
- x0 protection: write 0xFFFFFFFF to x0 with ID_Rs2 = 0 in the same cycle. RF_Rs2Data must be 0, and a later read of x0 must also be 0.
- Stall hold and update:
  - Read x3 = 0xA, then assert ID_Stall and change ID_Rs1 to 4. Output must stay 0xA.
  - During the stall, write x3 = 0xB. Output must become 0xB the next cycle.
  - Deassert the stall. Output must show the contents of x4.
- Reset mid-clear: assert rst when clr_cnt = 10. Clear must restart, and RF_Ready must go high 32 cycles after rst deasserts. A WB write issued during the clear must not be visible afterward.
